get_arbiter: RTL

//  Parametrised successor to the single-port FIFO get controller.

---
 rtl/get_arbiter_pkg.sv | 15 +
 rtl/get_arbiter_rr_pick.sv | 33 +++
 rtl/get_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/get_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO get arbiter.
// Holds the FSM state encoding and modular index arithmetic.
package get_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  // Increment an index modulo n; n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/get_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr, with wrap.
// Reports the winner as one-hot and as an index, plus whether any request was set.
module get_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = PtrW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/get_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters onto a single FIFO read port with bounded bursts.
// Issues en_get/gnt combinationally and returns per-requester data_valid READ_LAT cycles later.
module get_arbiter
  import get_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_get,
  input  logic               empty,
  output logic               en_get,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] data_valid,
  output logic               busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0]    MaxCnt  = CntW'(MAX_BURST);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("get_arbiter: NUM_REQ out of range 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("get_arbiter: MAX_BURST out of range 1..255");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("get_arbiter: READ_LAT out of range 1..4");
  end

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [PtrW-1:0]    owner_inc;
  logic               release_c;
  logic [NUM_REQ-1:0] pick_req;
  logic [PtrW-1:0]    pick_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PtrW-1:0]    gidx_c;

  logic              vld_q [READ_LAT];
  logic [PtrW-1:0]   idx_q [READ_LAT];

  assign owner_oh  = OneHot0 << owner_q;
  assign owner_inc = PtrW'(wrap_inc(32'(owner_q), NUM_REQ));
  assign release_c = (state_q == StBurst) && (!req_get[owner_q] || cnt_q == MaxCnt);

  // On release the old owner is masked out and the search starts just above it.
  always_comb begin
    pick_req = req_get;
    pick_ptr = ptr_q;
    if (release_c) begin
      pick_req = req_get & ~owner_oh;
      pick_ptr = owner_inc;
    end
  end

  get_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_c   = '0;
    gidx_c  = owner_q;
    case (state_q)
      StIdle: begin
        if (pick_any && !empty) begin
          gnt_c  = pick_onehot;
          gidx_c = pick_idx;
          if (MAX_BURST == 1) begin
            ptr_d = PtrW'(wrap_inc(32'(pick_idx), NUM_REQ));
          end else begin
            state_d = StBurst;
            owner_d = pick_idx;
            cnt_d   = CntOne;
          end
        end
      end
      StBurst: begin
        if (!release_c) begin
          if (!empty) begin
            gnt_c = owner_oh;
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          ptr_d = owner_inc;
          if (!empty && pick_any) begin
            gnt_c   = pick_onehot;
            gidx_c  = pick_idx;
            owner_d = pick_idx;
            cnt_d   = CntOne;
          end else if (!empty && req_get[owner_q]) begin
            gnt_c = owner_oh;
            cnt_d = CntOne;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!reset_n) gnt_c = '0;
  end

  assign gnt    = gnt_c;
  assign en_get = |gnt_c;
  assign busy   = (state_q == StBurst);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= en_get;
      idx_q[0] <= gidx_c;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign data_valid = vld_q[READ_LAT-1] ? (OneHot0 << idx_q[READ_LAT-1]) : '0;

endmodule
